// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings and the
// saturating next-state helper used by every BHT counter.
package branch_predictor_pkg;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_RESET = CTR_WNT;

   localparam int unsigned DEF_INDEX_W = 3;
   localparam int unsigned DEF_PC_W    = 16;

   function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic up);
      logic [1:0] nxt;
      nxt = ctr;
      if (up) begin
         if (ctr != CTR_ST) nxt = ctr + 2'b01;
      end else begin
         if (ctr != CTR_SNT) nxt = ctr - 2'b01;
      end
      return nxt;
   endfunction

   function automatic logic [1:0] alloc_ctr(input logic taken);
      return taken ? CTR_WT : CTR_WNT;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter for one BHT entry; a load takes priority
// over a count so an allocation always lands on the requested value.
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic       i_up,
   input  logic       i_load,
   input  logic [1:0] i_load_val,
   output logic [1:0] o_ctr
);

   logic [1:0] r_ctr;
   logic [1:0] w_ctr_next;

   always_comb begin
      w_ctr_next = r_ctr;
      if (i_load) begin
         w_ctr_next = i_load_val;
      end else if (i_en) begin
         w_ctr_next = sat_next(r_ctr, i_up);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ctr <= CTR_RESET;
      end else begin
         r_ctr <= w_ctr_next;
      end
   end

   assign o_ctr = r_ctr;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB tagged by PC. Lookup is combinational from registered
// state; decode's resolution updates the entry for the IF/ID PC at the clock edge.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned INDEX_W = DEF_INDEX_W,
   parameter int unsigned PC_W    = DEF_PC_W
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [PC_W-1:0] i_pc_curr,
   output logic            o_predicted_taken,
   output logic [PC_W-1:0] o_predicted_target,
   input  logic [PC_W-1:0] i_if_id_pc_curr,
   input  logic            i_id_stall,
   input  logic            i_wen_bht,
   input  logic            i_actual_taken,
   input  logic            i_wen_btb,
   input  logic [PC_W-1:0] i_actual_target
);

   localparam int unsigned ENTRIES = 1 << INDEX_W;
   localparam int unsigned TAG_W   = PC_W - INDEX_W - 1;

   logic              r_valid  [ENTRIES];
   logic [TAG_W-1:0]  r_tag    [ENTRIES];
   logic [PC_W-1:0]   r_target [ENTRIES];

   logic [ENTRIES-1:0][1:0] w_ctr;
   logic [ENTRIES-1:0]      w_cnt_en;
   logic [ENTRIES-1:0]      w_alloc;
   logic [ENTRIES-1:0]      w_tgt_wr;

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit;
   logic [INDEX_W-1:0] w_uidx;
   logic [TAG_W-1:0]   w_utag;
   logic               w_uhit;
   logic               w_upd;
   logic [PC_W-1:0]    w_alloc_target;
   logic               w_unused_pc_lsb;

   // Bit 0 never participates: halfword-aligned fetch.
   assign w_unused_pc_lsb = i_pc_curr[0] ^ i_if_id_pc_curr[0];

   assign w_idx  = i_pc_curr[INDEX_W:1];
   assign w_tag  = i_pc_curr[PC_W-1:INDEX_W+1];
   assign w_uidx = i_if_id_pc_curr[INDEX_W:1];
   assign w_utag = i_if_id_pc_curr[PC_W-1:INDEX_W+1];

   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
   assign w_upd  = ~i_id_stall;

   assign o_predicted_taken  = w_hit & w_ctr[w_idx][1];
   assign o_predicted_target = w_hit ? r_target[w_idx] : '0;

   // A replace never inherits the old target.
   assign w_alloc_target = i_wen_btb ? i_actual_target : '0;

   always_comb begin
      w_cnt_en = '0;
      w_alloc  = '0;
      w_tgt_wr = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         if (w_upd && (w_uidx == INDEX_W'(i))) begin
            w_cnt_en[i] = i_wen_bht & w_uhit;
            w_alloc[i]  = i_wen_bht & ~w_uhit;
            w_tgt_wr[i] = i_wen_btb & w_uhit;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            if (w_alloc[i]) begin
               r_valid[i]  <= 1'b1;
               r_tag[i]    <= w_utag;
               r_target[i] <= w_alloc_target;
            end else if (w_tgt_wr[i]) begin
               r_target[i] <= i_actual_target;
            end
         end
      end
   end

   for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_ctr
      bp_sat_counter u_ctr (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_en       (w_cnt_en[g]),
         .i_up       (i_actual_taken),
         .i_load     (w_alloc[g]),
         .i_load_val (alloc_ctr(i_actual_taken)),
         .o_ctr      (w_ctr[g])
      );
   end

endmodule
